// File: rtl/hazard_scoreboard.sv
// Destination-tag shadow of the DX/XM/MW stages with load-use stall generation
// and a saturating stall-cycle counter.
`timescale 1ns/1ps
module hazard_scoreboard #(
  parameter int unsigned REG_BITS  = 3,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 DValid,
  input  logic [REG_BITS-1:0]  DRs,
  input  logic [REG_BITS-1:0]  DRt,
  input  logic                 DUsesRs,
  input  logic                 DUsesRt,
  input  logic                 DWriteToReg,
  input  logic [REG_BITS-1:0]  DRd,
  input  logic                 DIsLoad,
  input  logic                 MemBusy,
  input  logic                 Flush,
  output logic                 Stall,
  output logic                 XMWriteToReg,
  output logic [REG_BITS-1:0]  XMRd,
  output logic                 MWWriteToReg,
  output logic [REG_BITS-1:0]  MWRd,
  output logic [CNT_WIDTH-1:0] StallCount
);

  logic                 dx_valid_q, dx_valid_d, dx_wr_q, dx_wr_d, dx_ld_q, dx_ld_d;
  logic [REG_BITS-1:0]  dx_rd_q, dx_rd_d;
  logic                 xm_valid_q, xm_valid_d, xm_wr_q, xm_wr_d;
  logic [REG_BITS-1:0]  xm_rd_q, xm_rd_d;
  logic                 mw_valid_q, mw_valid_d, mw_wr_q, mw_wr_d;
  logic [REG_BITS-1:0]  mw_rd_q, mw_rd_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 lu;

  always_comb begin
    lu = DValid & dx_valid_q & dx_ld_q & dx_wr_q &
         ((DUsesRs & (DRs == dx_rd_q)) | (DUsesRt & (DRt == dx_rd_q)));
    // Gated by rst_n so Stall drops the moment reset asserts.
    Stall = rst_n & (MemBusy | (~Flush & lu));

    dx_valid_d = dx_valid_q;
    dx_wr_d    = dx_wr_q;
    dx_ld_d    = dx_ld_q;
    dx_rd_d    = dx_rd_q;
    xm_valid_d = xm_valid_q;
    xm_wr_d    = xm_wr_q;
    xm_rd_d    = xm_rd_q;
    mw_valid_d = mw_valid_q;
    mw_wr_d    = mw_wr_q;
    mw_rd_d    = mw_rd_q;

    if (!MemBusy) begin
      mw_valid_d = xm_valid_q;
      mw_wr_d    = xm_wr_q;
      mw_rd_d    = xm_rd_q;
      xm_valid_d = dx_valid_q;
      xm_wr_d    = dx_wr_q;
      xm_rd_d    = dx_rd_q;
      // A bubble only clears valid; the other fields keep their last value.
      if (Flush || lu) begin
        dx_valid_d = 1'b0;
      end else begin
        dx_valid_d = DValid;
        dx_wr_d    = DWriteToReg;
        dx_ld_d    = DIsLoad;
        dx_rd_d    = DRd;
      end
    end

    cnt_d = (Stall && (cnt_q != '1)) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dx_valid_q <= 1'b0;
      dx_wr_q    <= 1'b0;
      dx_ld_q    <= 1'b0;
      dx_rd_q    <= '0;
      xm_valid_q <= 1'b0;
      xm_wr_q    <= 1'b0;
      xm_rd_q    <= '0;
      mw_valid_q <= 1'b0;
      mw_wr_q    <= 1'b0;
      mw_rd_q    <= '0;
      cnt_q      <= '0;
    end else begin
      dx_valid_q <= dx_valid_d;
      dx_wr_q    <= dx_wr_d;
      dx_ld_q    <= dx_ld_d;
      dx_rd_q    <= dx_rd_d;
      xm_valid_q <= xm_valid_d;
      xm_wr_q    <= xm_wr_d;
      xm_rd_q    <= xm_rd_d;
      mw_valid_q <= mw_valid_d;
      mw_wr_q    <= mw_wr_d;
      mw_rd_q    <= mw_rd_d;
      cnt_q      <= cnt_d;
    end
  end

  assign XMWriteToReg = xm_valid_q & xm_wr_q;
  assign XMRd         = xm_rd_q;
  assign MWWriteToReg = mw_valid_q & mw_wr_q;
  assign MWRd         = mw_rd_q;
  assign StallCount   = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic, all checked
// every cycle against a stage-array model of the pipeline.
`timescale 1ns/1ps
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       DValid, DUsesRs, DUsesRt, DWriteToReg, DIsLoad, MemBusy, Flush;
  logic [2:0] DRs, DRt, DRd;
  logic       Stall, XMWriteToReg, MWWriteToReg;
  logic [2:0] XMRd, MWRd;
  logic [15:0] StallCount;

  hazard_scoreboard #(.REG_BITS(3), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .DValid(DValid), .DRs(DRs), .DRt(DRt),
    .DUsesRs(DUsesRs), .DUsesRt(DUsesRt), .DWriteToReg(DWriteToReg), .DRd(DRd),
    .DIsLoad(DIsLoad), .MemBusy(MemBusy), .Flush(Flush), .Stall(Stall),
    .XMWriteToReg(XMWriteToReg), .XMRd(XMRd), .MWWriteToReg(MWWriteToReg),
    .MWRd(MWRd), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit       v;
    bit       w;
    bit       l;
    bit [2:0] rd;
  } ent_t;

  ent_t pipe [3];  // 0 = DX, 1 = XM, 2 = MW
  int   m_cnt;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    m_cnt = 0;
  endtask

  function automatic bit m_lu();
    return DValid && pipe[0].v && pipe[0].l && pipe[0].w &&
           ((DUsesRs && DRs == pipe[0].rd) || (DUsesRt && DRt == pipe[0].rd));
  endfunction

  function automatic bit m_stall();
    return rst_n && (MemBusy || (!Flush && m_lu()));
  endfunction

  task automatic model_check();
    chk("Stall", int'(Stall), int'(m_stall()));
    chk("XMWriteToReg", int'(XMWriteToReg), int'(pipe[1].v && pipe[1].w));
    chk("XMRd", int'(XMRd), int'(pipe[1].rd));
    chk("MWWriteToReg", int'(MWWriteToReg), int'(pipe[2].v && pipe[2].w));
    chk("MWRd", int'(MWRd), int'(pipe[2].rd));
    chk("StallCount", int'(StallCount), m_cnt);
  endtask

  task automatic model_update();
    bit st, lu;
    if (!rst_n) begin
      mreset();
    end else begin
      st = m_stall();
      lu = m_lu();
      if (st && m_cnt < 65535) m_cnt++;
      if (!MemBusy) begin
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (Flush || lu) pipe[0].v = 1'b0;
        else pipe[0] = '{v: DValid, w: DWriteToReg, l: DIsLoad, rd: DRd};
      end
    end
  endtask

  // Check at negedge, advance model at posedge, return at posedge+1.
  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_d(input bit v, input bit [2:0] rs, input bit [2:0] rt, input bit urs,
                       input bit urt, input bit wr, input bit [2:0] rd, input bit ld);
    DValid = v; DRs = rs; DRt = rt; DUsesRs = urs; DUsesRt = urt;
    DWriteToReg = wr; DRd = rd; DIsLoad = ld;
  endtask

  initial begin
    rst_n = 1'b0; MemBusy = 1'b0; Flush = 1'b0;
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    mreset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall", int'(Stall), 0);
    chk("reset_count", int'(StallCount), 0);
    rst_n = 1'b1;

    // Drain: ADD r3 followed by bubbles.
    set_d(1, 0, 0, 0, 0, 1, 3, 0);
    step();
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("drain_xm_wr", int'(XMWriteToReg), 1);
    chk("drain_xm_rd", int'(XMRd), 3);
    step();
    chk("drain_mw_wr", int'(MWWriteToReg), 1);
    chk("drain_mw_rd", int'(MWRd), 3);
    step();
    chk("drain_xm_empty", int'(XMWriteToReg), 0);
    chk("drain_mw_empty", int'(MWWriteToReg), 0);

    // Load-use: LD r2 then ADD r5 reading r2.
    set_d(1, 0, 0, 0, 0, 1, 2, 1);
    step();
    set_d(1, 2, 0, 1, 0, 1, 5, 0);
    #1;
    chk("lu_stall", int'(Stall), 1);
    step();
    chk("lu_released", int'(Stall), 0);
    chk("lu_xm_load", int'(XMRd), 2);
    step();
    chk("lu_xm_bubble", int'(XMWriteToReg), 0);
    chk("lu_count", int'(StallCount), 1);
    // Same with the source marked unused.
    set_d(1, 0, 0, 0, 0, 1, 2, 1);
    step();
    set_d(1, 2, 0, 0, 0, 1, 5, 0);
    #1;
    chk("unused_rs_nostall", int'(Stall), 0);
    step();
    chk("unused_rs_count", int'(StallCount), 1);

    // MemBusy freeze during a hazard: ADD r1, LD r5, consumer of r5 via Rt.
    set_d(1, 0, 0, 0, 0, 1, 1, 0);
    step();
    set_d(1, 0, 0, 0, 0, 1, 5, 1);
    step();
    set_d(1, 0, 5, 0, 1, 1, 6, 0);
    MemBusy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("busy_stall", int'(Stall), 1);
      chk("busy_xm_wr", int'(XMWriteToReg), 1);
      chk("busy_xm_rd", int'(XMRd), 1);
      step();
    end
    MemBusy = 1'b0;
    #1;
    chk("busy_lu_stall", int'(Stall), 1);
    step();
    chk("busy_after", int'(Stall), 0);
    step();
    chk("busy_count", int'(StallCount), 5);

    // Flush together with a load-use hazard.
    set_d(1, 0, 0, 0, 0, 1, 4, 1);
    step();
    set_d(1, 4, 0, 1, 0, 1, 7, 0);
    Flush = 1'b1;
    #1;
    chk("flush_nostall", int'(Stall), 0);
    step();
    Flush = 1'b0;
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    chk("flush_xm_load", int'(XMRd), 4);
    chk("flush_count", int'(StallCount), 5);
    step();
    chk("flush_xm_bubble", int'(XMWriteToReg), 0);

    // Reset asserted mid-stream with XM/MW valid and Stall high.
    set_d(1, 0, 0, 0, 0, 1, 6, 0);
    step();
    set_d(1, 0, 0, 0, 0, 1, 7, 0);
    step();
    set_d(1, 0, 0, 0, 0, 1, 1, 0);
    step();
    chk("pre_reset_mw", int'(MWWriteToReg), 1);
    MemBusy = 1'b1;
    step();
    #2;
    rst_n = 1'b0;
    mreset();
    #1;
    chk("rst_xm_wr", int'(XMWriteToReg), 0);
    chk("rst_mw_wr", int'(MWWriteToReg), 0);
    chk("rst_xm_rd", int'(XMRd), 0);
    chk("rst_mw_rd", int'(MWRd), 0);
    chk("rst_stall", int'(Stall), 0);
    chk("rst_count", int'(StallCount), 0);
    step();
    rst_n = 1'b1;
    MemBusy = 1'b0;

    // Random traffic over a small register range so hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      set_d($urandom_range(0, 9) < 8, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), $urandom_range(0, 9) < 8, 3'($urandom_range(0, 3)),
            $urandom_range(0, 2) == 0);
      MemBusy = $urandom_range(0, 9) == 0;
      Flush   = $urandom_range(0, 9) == 0;
      if (i == 1500) begin
        #2;
        rst_n = 1'b0;
        mreset();
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    // Saturation.
    Flush = 1'b0;
    MemBusy = 1'b1;
    repeat (65541) step();
    chk("sat_count", int'(StallCount), 16'hFFFF);
    repeat (3) step();
    chk("sat_hold", int'(StallCount), 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
